// File: rtl/icache_sa.sv
// Set-associative instruction cache: combinational lookup, beat-by-beat line refill,
// tree-PLRU replacement with invalid-way-first fill, and a set-serial fence.i flush.
module icache_sa #(
    parameter int unsigned          WAYS       = 4,
    parameter int unsigned          SETS       = 64,
    parameter int unsigned          LINE_BYTES = 64,
    parameter int unsigned          ADDR_W     = 64,
    parameter logic [ADDR_W-1:0]    CACHE_BASE = ADDR_W'('h8000_0000)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               core_req_i,
    input  logic [ADDR_W-1:0]                  core_addr_i,
    output logic [31:0]                        core_data_o,
    output logic                               core_valid_o,
    output logic                               core_err_o,
    input  logic                               flush_i,
    output logic                               flush_busy_o,
    output logic                               axi_req,
    output logic [ADDR_W-1:0]                  axi_req_addr,
    input  logic                               axi_done,
    input  logic [63:0]                        axi_data_i,
    output logic [$clog2(LINE_BYTES/8)-1:0]    axi_fifo_idx,
    output logic                               axi_fifo_done
);

    localparam int unsigned BEATS = LINE_BYTES / 8;
    localparam int unsigned OB    = $clog2(LINE_BYTES);
    localparam int unsigned IB    = $clog2(SETS);
    localparam int unsigned WB    = $clog2(WAYS);
    localparam int unsigned BB    = $clog2(BEATS);
    localparam int unsigned TAG_W = ADDR_W - OB - IB;

    typedef enum logic [1:0] {StIdle, StRefill, StCommit, StFlush} state_e;

    state_e             state_q, state_d;
    logic               flush_pend_q, flush_pend_d;
    logic [IB-1:0]      fset_q, fset_d;
    logic [BB-1:0]      beat_q, beat_d;
    logic [IB-1:0]      ridx_q, ridx_d;
    logic [TAG_W-1:0]   rtag_q, rtag_d;
    logic [WB-1:0]      rway_q, rway_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;

    // PLRU tree stored heap-style in bits [WAYS-1:1]; bit 0 is unused.
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    plru_q  [SETS];
    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [63:0]        data_q  [WAYS][SETS][BEATS];

    logic [IB-1:0]      idx;
    logic [TAG_W-1:0]   tag;
    logic [BB-1:0]      beat;
    logic               cacheable, hit_any, hit, miss, inv_found;
    logic [WB-1:0]      hit_way, inv_way, plru_way, victim;
    logic [63:0]        hit_beat;
    logic               unused_addr_bits;

    assign idx              = core_addr_i[OB+IB-1:OB];
    assign tag              = core_addr_i[ADDR_W-1:OB+IB];
    assign beat             = core_addr_i[OB-1:3];
    assign cacheable        = core_addr_i >= CACHE_BASE;
    assign unused_addr_bits = ^core_addr_i[1:0];

    function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] cur,
                                                   input logic [WB-1:0]   way);
        logic [WAYS-1:0] nxt;
        logic [WB-1:0]   node;
        logic [WB-1:0]   w;
        logic            d;
        nxt  = cur;
        node = WB'(1);
        w    = way;
        for (int l = 0; l < WB; l++) begin
            d         = w[WB-1];
            nxt[node] = ~d;
            node      = WB'({node, d});
            w         = w << 1;
        end
        return nxt;
    endfunction

    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit_any = 1'b1;
                hit_way = WB'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WB'(w);
            end
        end
        // Walk the tree; the final truncated heap index is the way number.
        plru_way = WB'(1);
        for (int l = 0; l < WB; l++) begin
            plru_way = WB'({plru_way, plru_q[idx][plru_way]});
        end
        victim = inv_found ? inv_way : plru_way;
    end

    assign hit  = (state_q == StIdle) && core_req_i && cacheable && hit_any;
    assign miss = (state_q == StIdle) && core_req_i && cacheable && !hit_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            flush_pend_q <= 1'b0;
            fset_q       <= '0;
            beat_q       <= '0;
            ridx_q       <= '0;
            rtag_q       <= '0;
            rway_q       <= '0;
            raddr_q      <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            fset_q       <= fset_d;
            beat_q       <= beat_d;
            ridx_q       <= ridx_d;
            rtag_q       <= rtag_d;
            rway_q       <= rway_d;
            raddr_q      <= raddr_d;
            if (hit) begin
                plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
            end
            if (state_q == StCommit) begin
                valid_q[ridx_q][rway_q] <= 1'b1;
                plru_q[ridx_q]          <= plru_touch(plru_q[ridx_q], rway_q);
            end
            if (state_q == StFlush) begin
                valid_q[fset_q] <= '0;
                plru_q[fset_q]  <= '0;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (!rst && state_q == StCommit) begin
            tag_q[ridx_q][rway_q] <= rtag_q;
        end
        if (!rst && state_q == StRefill && axi_done) begin
            data_q[rway_q][ridx_q][beat_q] <= axi_data_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        fset_d       = fset_q;
        beat_d       = beat_q;
        ridx_d       = ridx_q;
        rtag_d       = rtag_q;
        rway_d       = rway_q;
        raddr_d      = raddr_q;
        unique case (state_q)
            StIdle: begin
                if (flush_i || flush_pend_q) begin
                    state_d      = StFlush;
                    fset_d       = '0;
                    flush_pend_d = 1'b0;
                end else if (miss) begin
                    state_d = StRefill;
                    beat_d  = '0;
                    ridx_d  = idx;
                    rtag_d  = tag;
                    rway_d  = victim;
                    raddr_d = {core_addr_i[ADDR_W-1:OB], {OB{1'b0}}};
                end
            end
            StRefill: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (axi_done) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BB'(BEATS - 1)) begin
                        state_d = StCommit;
                    end
                end
            end
            StCommit: begin
                if (flush_i || flush_pend_q) begin
                    state_d      = StFlush;
                    fset_d       = '0;
                    flush_pend_d = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            StFlush: begin
                fset_d = fset_q + 1'b1;
                if (fset_q == IB'(SETS - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hit_beat      = data_q[hit_way][idx][beat];
        core_data_o   = core_addr_i[2] ? hit_beat[63:32] : hit_beat[31:0];
        core_valid_o  = hit;
        core_err_o    = (state_q == StIdle) && core_req_i && !cacheable;
        flush_busy_o  = flush_pend_q || (state_q == StFlush);
        axi_req       = (state_q == StRefill);
        axi_req_addr  = raddr_q;
        axi_fifo_idx  = beat_q;
        axi_fifo_done = (state_q == StCommit);
    end

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa: table-driven fetch vectors with a scoreboard queue,
// a background AXI beat responder, and hand sequences for flush and reset corners.
module tb_icache_sa;

    localparam int KH = 0;  // hit, no refill
    localparam int KM = 1;  // miss, refill, then hit
    localparam int KE = 2;  // uncacheable error
    localparam int BEATS = 8;

    typedef struct {
        logic [63:0] addr;
        int          kind;
        int          gap;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        int          kind;
        int          gap;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req_i;
    logic [63:0] core_addr_i;
    logic [31:0] core_data_o;
    logic        core_valid_o;
    logic        core_err_o;
    logic        flush_i;
    logic        flush_busy_o;
    logic        axi_req;
    logic [63:0] axi_req_addr;
    logic        axi_done;
    logic [63:0] axi_data_i;
    logic [2:0]  axi_fifo_idx;
    logic        axi_fifo_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   gap      = 0;
    int   tb_beat  = 0;
    int   gap_cnt  = 0;
    exp_t sb[$];
    vec_t vecs[18];

    icache_sa dut (
        .clk           (clk),
        .rst           (rst),
        .core_req_i    (core_req_i),
        .core_addr_i   (core_addr_i),
        .core_data_o   (core_data_o),
        .core_valid_o  (core_valid_o),
        .core_err_o    (core_err_o),
        .flush_i       (flush_i),
        .flush_busy_o  (flush_busy_o),
        .axi_req       (axi_req),
        .axi_req_addr  (axi_req_addr),
        .axi_done      (axi_done),
        .axi_data_i    (axi_data_i),
        .axi_fifo_idx  (axi_fifo_idx),
        .axi_fifo_done (axi_fifo_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_0000;
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] line, input int b);
        logic [63:0] lo;
        lo = line + 64'(b * 8);
        return {word(lo + 64'd4), word(lo)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // AXI side: one beat every (gap+1) cycles while a refill is requested.
    initial begin
        axi_done   = 1'b0;
        axi_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!axi_req) begin
                axi_done = 1'b0;
                tb_beat  = 0;
                gap_cnt  = gap;
            end else if (gap_cnt >= gap) begin
                check("fifo idx", 64'(axi_fifo_idx), 64'(tb_beat));
                axi_done   = 1'b1;
                axi_data_i = beat_data(axi_req_addr, tb_beat);
                tb_beat++;
                gap_cnt = 0;
            end else begin
                axi_done = 1'b0;
                gap_cnt++;
            end
        end
    end

    task automatic fetch(input logic [63:0] a, input int kind, input int g);
        exp_t e;
        bit   resp;
        bit   saw;
        int   lat;
        int   pulses;
        gap = g;
        sb.push_back('{a, kind, g, word(a)});
        @(posedge clk);
        #1;
        core_req_i  = 1'b1;
        core_addr_i = a;
        resp   = 1'b0;
        saw    = 1'b0;
        lat    = 0;
        pulses = 0;
        for (int i = 0; i < 400 && !resp; i++) begin
            @(negedge clk);
            if (axi_fifo_done) pulses++;
            if (axi_req && !saw) begin
                saw = 1'b1;
                check("axi_req_addr", axi_req_addr, {a[63:6], 6'b0});
            end
            if (core_valid_o || core_err_o) begin
                resp = 1'b1;
                lat  = i;
            end
        end
        e = sb.pop_front();
        check("response seen", 64'(resp), 64'd1);
        if (e.kind == KE) begin
            check("err_o", 64'(core_err_o), 64'd1);
            check("valid_o on err", 64'(core_valid_o), 64'd0);
            check("axi on err", 64'(saw), 64'd0);
        end else begin
            check("valid_o", 64'(core_valid_o), 64'd1);
            check("data_o", 64'(core_data_o), 64'(e.data));
            check("refill issued", 64'(saw), 64'(e.kind == KM));
            check("fifo_done pulses", 64'(pulses), 64'(e.kind == KM));
            check("latency", 64'(lat),
                  (e.kind == KM) ? 64'(2 + BEATS + e.gap * (BEATS - 1)) : 64'd0);
        end
        @(posedge clk);
        #1;
        core_req_i = 1'b0;
    endtask

    task automatic count_flush(output int cnt, output int bad);
        cnt = 0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!flush_busy_o) break;
            cnt++;
            if (core_valid_o) bad++;
        end
    endtask

    task automatic wait_valid(input string name, input logic [63:0] a);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (core_valid_o) got = 1'b1;
        end
        check({name, " response"}, 64'(got), 64'd1);
        if (got) check({name, " data"}, 64'(core_data_o), 64'(word(a)));
    endtask

    task automatic wait_idx3(output bit found);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (axi_req && axi_fifo_idx == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int bad;
        bit found;

        // Set 0 tags A..E at 0x8000_0000 + n*0x1000. Tree after A,B,C,D then hit A:
        // root points right, node for ways 2/3 points at way 2, so E evicts C.
        vecs[0]  = '{64'h8000_0044, KM, 0};
        vecs[1]  = '{64'h8000_0078, KH, 0};
        vecs[2]  = '{64'h8000_0040, KH, 0};
        vecs[3]  = '{64'h0000_1000, KE, 0};
        vecs[4]  = '{64'h8000_0000, KM, 0};
        vecs[5]  = '{64'h8000_1004, KM, 0};
        vecs[6]  = '{64'h8000_2008, KM, 0};
        vecs[7]  = '{64'h8000_300C, KM, 0};
        vecs[8]  = '{64'h8000_0010, KH, 0};
        vecs[9]  = '{64'h8000_4000, KM, 0};
        vecs[10] = '{64'h8000_0000, KH, 0};
        vecs[11] = '{64'h8000_1000, KH, 0};
        vecs[12] = '{64'h8000_3000, KH, 0};
        vecs[13] = '{64'h8000_2000, KM, 0};
        vecs[14] = '{64'h8000_0000, KM, 0};
        vecs[15] = '{64'h8000_0084, KM, 2};
        vecs[16] = '{64'h8000_00BC, KH, 0};
        vecs[17] = '{64'h8000_0044, KH, 0};

        rst         = 1'b1;
        core_req_i  = 1'b0;
        core_addr_i = '0;
        flush_i     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset axi_req", 64'(axi_req), 64'd0);
        check("reset axi_req_addr", axi_req_addr, 64'd0);
        check("reset fifo_idx", 64'(axi_fifo_idx), 64'd0);
        check("reset fifo_done", 64'(axi_fifo_done), 64'd0);
        check("reset valid_o", 64'(core_valid_o), 64'd0);
        check("reset err_o", 64'(core_err_o), 64'd0);
        check("reset flush_busy", 64'(flush_busy_o), 64'd0);

        foreach (vecs[i]) fetch(vecs[i].addr, vecs[i].kind, vecs[i].gap);

        // Flush from idle; the hit presented alongside the pulse still completes.
        gap = 0;
        @(posedge clk);
        #1;
        flush_i     = 1'b1;
        core_req_i  = 1'b1;
        core_addr_i = 64'h8000_0044;
        @(negedge clk);
        check("hit in flush cycle", 64'(core_valid_o), 64'd1);
        check("hit data in flush cycle", 64'(core_data_o), 64'(word(64'h8000_0044)));
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        count_flush(cnt, bad);
        check("flush busy cycles", 64'(cnt), 64'd64);
        check("valid during flush", 64'(bad), 64'd0);
        check("flushed line misses", 64'(core_valid_o), 64'd0);
        wait_valid("refetch after flush", 64'h8000_0044);
        @(posedge clk);
        #1;
        core_req_i = 1'b0;
        fetch(64'h8000_3000, KM, 0);

        // Flush arriving mid-refill is deferred past commit and kills the new line.
        @(posedge clk);
        #1;
        core_req_i  = 1'b1;
        core_addr_i = 64'h8000_0100;
        wait_idx3(found);
        check("refill reached beat 3", 64'(found), 64'd1);
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        check("flush pending busy", 64'(flush_busy_o), 64'd1);
        check("refill continues", 64'(axi_req), 64'd1);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (axi_fifo_done) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("fifo_done after deferred flush", 64'(found), 64'd1);
        check("busy at commit", 64'(flush_busy_o), 64'd1);
        count_flush(cnt, bad);
        check("deferred flush cycles", 64'(cnt), 64'd64);
        check("valid during deferred flush", 64'(bad), 64'd0);
        check("flushed refill misses", 64'(core_valid_o), 64'd0);
        wait_valid("refetch after deferred flush", 64'h8000_0100);
        @(posedge clk);
        #1;
        core_req_i = 1'b0;

        // Reset during refill: request drops and the partial line never becomes valid.
        @(posedge clk);
        #1;
        core_req_i  = 1'b1;
        core_addr_i = 64'h8000_0200;
        wait_idx3(found);
        check("rst test reached beat 3", 64'(found), 64'd1);
        rst        = 1'b1;
        core_req_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("axi_req after rst", 64'(axi_req), 64'd0);
        check("fifo_done after rst", 64'(axi_fifo_done), 64'd0);
        check("fifo_idx after rst", 64'(axi_fifo_idx), 64'd0);
        fetch(64'h8000_0200, KM, 0);
        fetch(64'h8000_0044, KM, 0);
        fetch(64'h0000_0FFC, KE, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
